// File: rtl/uart_tx_mmio_if.sv
// Write-port bundle between the CPU store path and the MMIO UART transmitter.
// master = CPU side, slave = transmitter side.
interface uart_tx_mmio_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_data_in;
  logic          tx_we_in;
  logic          tx_busy_out;
  logic          tx_serial_out;
  logic [CW-1:0] fifo_count_out;
  logic          overflow_out;

  modport master (
    output tx_data_in, tx_we_in,
    input  tx_busy_out, tx_serial_out, fifo_count_out, overflow_out
  );

  modport slave (
    input  tx_data_in, tx_we_in,
    output tx_busy_out, tx_serial_out, fifo_count_out, overflow_out
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: byte-write FIFO feeding an 8N1 LSB-first serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
//
// state  | meaning
// IDLE   | line high, waiting for a FIFO entry
// START  | start bit (line low)
// DATA   | shifting data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (line high); pops the next byte at its end
module uart_tx_mmio #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_mmio_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  state_t        w_state_nxt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    w_bit_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_nonempty;
  logic          w_baud_done;
  logic          w_tx;

  assign w_nonempty  = (r_count != '0);
  assign w_baud_done = (r_baud == BAUD_LAST);
  // A full FIFO still takes a write when the serializer pops in the same cycle.
  assign w_push      = bus.tx_we_in && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.tx_we_in && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_wr_ptr] <= bus.tx_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      if (w_pop) r_shift <= r_mem[r_rd_ptr];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_bit_nxt  = '0;
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      S_DATA: begin
        w_tx = r_shift[r_bit];
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx = ^r_shift;
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          // Chain straight into the next frame when data is waiting.
          if (w_nonempty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  assign bus.tx_serial_out  = w_tx;
  assign bus.tx_busy_out    = (r_count == FULL_CNT);
  assign bus.fifo_count_out = r_count;
  assign bus.overflow_out   = r_overflow;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
  localparam int CLK_HZ     = 1000;
  localparam int BAUD       = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int CPB        = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FRAME = NSLOT * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_tx_mmio_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_tx_mmio #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Model: byte queue plus "which cycle of which frame is on the line".
  logic [7:0]       mq[$];
  bit               m_active = 1'b0;
  int               m_pos    = 0;
  logic [NSLOT-1:0] m_slots  = '1;
  bit               m_ovf    = 1'b0;

  function automatic logic [NSLOT-1:0] frame_of(input logic [7:0] d);
    logic [NSLOT-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      if (m_active && m_pos < FRAME - 1) begin
        m_pos++;
      end else begin
        m_active = 1'b0;
        if (mq.size() > 0) begin
          m_slots  = frame_of(mq.pop_front());
          m_active = 1'b1;
          m_pos    = 0;
        end
      end
      if (bus.tx_we_in) begin
        if (mq.size() < FIFO_DEPTH) mq.push_back(bus.tx_data_in);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_line;
    exp_line = m_active ? 1'(m_slots >> (m_pos / CPB)) : 1'b1;
    chk("line", 32'(bus.tx_serial_out), 32'(exp_line));
    chk("count", 32'(bus.fifo_count_out), 32'(mq.size()));
    chk("busy", 32'(bus.tx_busy_out), 32'(mq.size() == FIFO_DEPTH));
    chk("overflow", 32'(bus.overflow_out), 32'(m_ovf));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    bus.tx_we_in   = 1'b1;
    bus.tx_data_in = d;
    @(negedge clk);
    bus.tx_we_in   = 1'b0;
    bus.tx_data_in = 8'($urandom);
  endtask

  initial begin
    logic [10:0] exp1;
    int          pct;
    bus.tx_we_in   = 1'b0;
    bus.tx_data_in = 8'h00;
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    chk("rst_line", 32'(bus.tx_serial_out), 32'd1);
    chk("rst_count", 32'(bus.fifo_count_out), 32'd0);
    chk("rst_busy", 32'(bus.tx_busy_out), 32'd0);
    chk("rst_ovf", 32'(bus.overflow_out), 32'd0);

    // Single 0x55 frame, one sample every half bit.
    idle(2);
`ifdef UART_TX_PARITY_EN
    exp1 = 11'b10010101010;
`else
    exp1 = 11'b11010101010;
`endif
    wr(8'h55);
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k == 0) chk("t1_count", 32'(bus.fifo_count_out), 32'd0);
      if (k % 5 == 0) chk("t1_line", 32'(bus.tx_serial_out), 32'(1'(exp1 >> (k / 10))));
    end

    // Burst of five: first byte leaves as the second arrives.
    idle(5);
    for (int i = 0; i < 5; i++) wr(8'h41 + 8'(i));
    chk("t2_busy", 32'(bus.tx_busy_out), 32'd1);
    chk("t2_count", 32'(bus.fifo_count_out), 32'd4);
    chk("t2_ovf", 32'(bus.overflow_out), 32'd0);
    idle(5 * FRAME + 10);
    chk("t2_drained", 32'(bus.fifo_count_out), 32'd0);
    chk("t2_ovf_end", 32'(bus.overflow_out), 32'd0);

    // Overflow: one in flight, four queued, sixth write dropped.
    for (int i = 0; i < 6; i++) wr(8'($urandom));
    chk("t3_ovf", 32'(bus.overflow_out), 32'd1);
    chk("t3_count", 32'(bus.fifo_count_out), 32'd4);
    chk("t3_busy", 32'(bus.tx_busy_out), 32'd1);
    idle(5 * FRAME + 10);
    chk("t3_ovf_sticky", 32'(bus.overflow_out), 32'd1);

    // Reset on the 40th cycle of a 0x0F frame with two bytes queued.
    wr(8'h0F);
    wr(8'h3C);
    wr(8'hA5);
    idle(37);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_line", 32'(bus.tx_serial_out), 32'd1);
    chk("t5_count", 32'(bus.fifo_count_out), 32'd0);
    chk("t5_ovf", 32'(bus.overflow_out), 32'd0);
    rst = 1'b1;
    idle(3);
    wr(8'($urandom));
    idle(FRAME + 5);
    chk("t5_clean_idle", 32'(bus.tx_serial_out), 32'd1);

    // Write while full lands on the STOP-end pop edge.
    wr(8'($urandom));
    for (int i = 0; i < 4; i++) wr(8'($urandom));
    idle(FRAME - 4);
    wr(8'hC3);
    chk("t4_count", 32'(bus.fifo_count_out), 32'd4);
    chk("t4_ovf", 32'(bus.overflow_out), 32'd0);
    idle(5 * FRAME + 10);
    chk("t4_drained", 32'(bus.fifo_count_out), 32'd0);

`ifdef UART_TX_PARITY_EN
    wr(8'h07);
    for (int k = 0; k <= 110; k++) begin
      @(negedge clk);
      if (k == 85) chk("t6_bit7", 32'(bus.tx_serial_out), 32'd0);
      if (k == 95) chk("t6_parity", 32'(bus.tx_serial_out), 32'd1);
      if (k == 105) chk("t6_stop", 32'(bus.tx_serial_out), 32'd1);
    end
`endif

    // Randomized traffic: alternating light and heavy write phases.
    for (int ph = 0; ph < 6; ph++) begin
      pct = (ph % 2 == 1) ? 60 : 3;
      if (ph == 3) begin
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
      end
      for (int c = 0; c < 500; c++) begin
        bus.tx_data_in = 8'($urandom);
        bus.tx_we_in   = ($urandom_range(0, 99) < pct);
        if ($urandom_range(0, 999) == 0) rst = 1'b0;
        else rst = 1'b1;
        @(negedge clk);
      end
      bus.tx_we_in = 1'b0;
      rst = 1'b1;
    end
    idle(6 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- MMIO-side UART transmitter: the peripheral end of the CPU's UART TX write port at 0x10000000.
- Accepts one-cycle byte-write strobes from the pipeline's MEM-stage store logic and buffers them in a small FIFO.
- Serializes bytes onto the TX pin as 8N1, LSB first.
- Reports a busy flag that the CPU polls through UART Status bit 1 before each store.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division (868 at defaults); must be >= 2.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- tx_data_in  input  8  byte from the CPU store (RegR2[7:0]).
- tx_we_in  input  1  write strobe; each high cycle is one write.
- tx_busy_out  output  1  high when the FIFO is full.
- tx_serial_out  output  1  UART TX line; idles high.
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_out  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset, sampled when rst==0 at a clk edge:
  - FIFO emptied; fifo_count_out=0.
  - State IDLE; tx_serial_out=1; tx_busy_out=0; overflow_out=0.
  - Baud counter and bit index cleared.
  - Reset mid-frame aborts the frame; the line is high from the first reset edge.
- FIFO:
  - Write accepted when tx_we_in=1 and (count<FIFO_DEPTH, or a pop occurs in the same cycle).
  - Accepted write stores tx_data_in at the tail.
  - Write while full with no same-cycle pop: byte dropped, overflow_out<=1, held until reset.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_busy_out = (count==FIFO_DEPTH), registered form of the count, no combinational path from tx_we_in.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Line high.
  - If FIFO is non-empty at an edge: pop head into the shift register, go to START, drive the line low at that same edge.
  - A byte written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1; the start bit begins at N+1.
- START: line 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - Line = shift[bit index], LSB first.
  - Each bit lasts CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP: line 1 for CLKS_PER_BIT cycles. At the end:
  - FIFO non-empty: pop and go directly to START, giving back-to-back frames with no idle gap.
  - FIFO empty: go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads on each bit transition; it does not run in IDLE.
- tx_data_in is ignored when tx_we_in=0.
- A byte being shifted is not affected by later writes.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is sent between bit 7 and STOP in an added PARITY state. Frame is 8E1, 11*CLKS_PER_BIT cycles.
- Undefined: 8N1 as above; the PARITY state and its logic are absent.

Test Plan:
Benches use CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10.
1. Reset, then a single write 0x55 at edge N:
   - Line low during [N+1, N+11).
   - Then 1,0,1,0,1,0,1,0, 10 cycles each.
   - Then high for 10 cycles; IDLE at N+101.
   - fifo_count_out returns to 0 at N+1.
2. Burst of 5 writes 0x41..0x45 on consecutive cycles, FIFO_DEPTH=4:
   - First byte popped at the second write's edge, so all 5 are accepted; tx_busy_out asserts after the 5th write.
   - Five contiguous frames, 500 cycles total, no idle gap.
   - overflow_out stays 0.
3. Fill the FIFO during a frame, then one more write with no pop:
   - Byte dropped; overflow_out=1 and stays high.
   - fifo_count_out stays 4.
4. Write when full in the same cycle as the STOP-end pop: write accepted, count stays 4.
5. rst=0 asserted at the 40th cycle of a 0x0F frame:
   - Line 1 from that edge; fifo_count_out=0; overflow_out=0.
   - A write after release sends a clean frame.
6. With UART_TX_PARITY_EN, write 0x07 (three ones):
   - Parity bit 1 for 10 cycles after bit 7, then stop.
   - Frame is 110 cycles.
